// File: rtl/pipeif_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select encodings.
package pipeif_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous DEPTH-entry FIFO with flush; head is combinational from the read pointer.
// Flush beats push; push and pop together on a full queue keep count unchanged.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             wr_en;
  logic             rd_en;

  // Guard against over/underflow even though the fetch control never requests it.
  assign rd_en = pop && (count != '0);
  assign wr_en = push && ((count != (AW+1)'(DEPTH)) || rd_en);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!resetn || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (resetn && !flush && wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pipeif_fq.sv
// Fetch stage: PC register, next-PC select, ROM issue and a fetch queue towards decode.
// Two-cycle issue-to-output latency; stalls issuing when queue plus in-flight fetch is full.
module pipeif_fq
  import pipeif_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              IADDR_W  = 6,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [1:0]         pcsource,
  input  logic [XLEN-1:0]    bpc,
  input  logic [XLEN-1:0]    da,
  input  logic [XLEN-1:0]    jpc,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_data,
  output logic [XLEN-1:0]    pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_ins,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_pc4
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
  } entry_t;

  logic [CW-1:0]   count;
  logic            inflight;
  logic [XLEN-1:0] pending_pc;
  logic [XLEN-1:0] target;
  logic            deq;
  logic            redirect;
  logic            issue;
  entry_t          head;
  entry_t          enq_entry;

  assign out_valid = (count != '0);
  assign deq       = out_valid & out_ready;
  assign redirect  = (pcsource != PCSRC_SEQ);
  // A dequeue this cycle frees a slot in time for the response of this issue.
  assign issue     = !redirect && (((count + CW'(inflight)) < CW'(DEPTH)) || deq);
  assign imem_addr = pc[IADDR_W+1:2];

  always_comb begin
    target = '0;
    case (pcsource)
      PCSRC_BR: target = bpc;
      PCSRC_JR: target = da;
      PCSRC_J:  target = jpc;
      default:  target = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pc         <= RESET_PC;
      inflight   <= 1'b0;
      pending_pc <= '0;
    end else if (redirect) begin
      pc       <= target & ~XLEN'(3);
      inflight <= 1'b0;
    end else if (issue) begin
      pc         <= pc + XLEN'(4);
      inflight   <= 1'b1;
      pending_pc <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  assign enq_entry.pc  = pending_pc;
  assign enq_entry.ins = imem_data;

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .flush  (redirect),
    .push   (inflight & ~redirect),
    .pop    (deq),
    .din    (enq_entry),
    .count  (count),
    .head   (head)
  );

  assign out_ins = out_valid ? head.ins : '0;
  assign out_pc  = out_valid ? head.pc : '0;
  assign out_pc4 = out_valid ? (head.pc + XLEN'(4)) : '0;

endmodule

// File: tb/tb_pipeif_fq.sv
// Scoreboard bench for pipeif_fq: driver queues expected {pc, ins}, negedge monitor checks deliveries.
module tb_pipeif_fq;

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  pcsource;
  logic [31:0] bpc, da, jpc;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins, out_pc, out_pc4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  pipeif_fq #(
    .XLEN     (32),
    .IADDR_W  (6),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .pcsource  (pcsource),
    .bpc       (bpc),
    .da        (da),
    .jpc       (jpc),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .pc        (pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ins   (out_ins),
    .out_pc    (out_pc),
    .out_pc4   (out_pc4)
  );

  // ROM: word i holds 0x1000 + i, registered address
  always @(posedge clock) imem_data <= 32'h1000 + {26'd0, imem_addr};

  function automatic exp_t mk(input logic [31:0] p);
    exp_t e;
    e.pc  = p;
    e.ins = 32'h1000 + {26'd0, p[7:2]};
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    pcsource = 2'b00;
    tick();
    resetn = 1'b1;
    exp_q.delete();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check("drain_left", exp_q.size(), 0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected: got pc=%h ins=%h want nothing", out_pc, out_ins);
      end else begin
        e = exp_q.pop_front();
        if (out_pc !== e.pc || out_ins !== e.ins || out_pc4 !== e.pc + 32'd4) begin
          bad++;
          $display("FAIL deliver: got pc=%h ins=%h pc4=%h want pc=%h ins=%h pc4=%h",
                   out_pc, out_ins, out_pc4, e.pc, e.ins, e.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; out_ready = 1'b0; pcsource = 2'b00;
    bpc = '0; da = '0; jpc = '0;

    // streaming after reset
    do_reset();
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_pc", pc, 32'h0);
    check("rst_ins", out_ins, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_pc4", out_pc4, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(32'(i * 4)));
    tick();
    check("lat1_valid", {31'd0, out_valid}, 0);
    tick();
    check("lat2_valid", {31'd0, out_valid}, 1);
    drain(50);
    out_ready = 1'b0;

    // decode stall fills the queue, then release
    do_reset();
    repeat (10) tick();
    check("stall_pc", pc, 32'h10);
    check("stall_head", out_pc, 32'h0);
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(32'(i * 4)));
    out_ready = 1'b1;
    drain(50);
    out_ready = 1'b0;

    // jump redirect from a full queue
    do_reset();
    repeat (10) tick();
    pcsource = 2'b11; jpc = 32'h40;
    tick();
    pcsource = 2'b00;
    check("j_flush", {31'd0, out_valid}, 0);
    check("j_pc", pc, 32'h40);
    out_ready = 1'b1;
    exp_q.push_back(mk(32'h40)); exp_q.push_back(mk(32'h44)); exp_q.push_back(mk(32'h48));
    tick();
    check("j_lat1_valid", {31'd0, out_valid}, 0);
    tick();
    check("j_lat2_pc", out_pc, 32'h40);
    drain(50);
    out_ready = 1'b0;

    // register jump with a dequeue in the redirect cycle
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(mk(32'h0));
    tick();
    tick();
    pcsource = 2'b10; da = 32'h23;
    exp_q.push_back(mk(32'h20)); exp_q.push_back(mk(32'h24));
    tick();
    pcsource = 2'b00;
    check("jr_pc", pc, 32'h20);
    check("jr_flush", {31'd0, out_valid}, 0);
    drain(50);
    out_ready = 1'b0;

    // reset in the middle with three entries queued
    do_reset();
    repeat (4) tick();
    check("mid_valid", {31'd0, out_valid}, 1);
    resetn = 1'b0;
    tick();
    check("mid_rst_valid", {31'd0, out_valid}, 0);
    check("mid_rst_pc", pc, 32'h0);
    resetn = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(32'(i * 4)));
    tick();
    check("mid_lat1_valid", {31'd0, out_valid}, 0);
    tick();
    check("mid_lat2_valid", {31'd0, out_valid}, 1);
    drain(50);
    out_ready = 1'b0;

    // PC wrap and ROM address aliasing
    do_reset();
    tick();
    pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
    tick();
    pcsource = 2'b00;
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_addr", {26'd0, imem_addr}, 32'd63);
    exp_q.push_back(mk(32'hFFFF_FFFC)); exp_q.push_back(mk(32'h0)); exp_q.push_back(mk(32'h4));
    out_ready = 1'b1;
    drain(50);
    out_ready = 1'b0;

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
